// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
package mem_stage_pkg;

  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

  // A double access is never aligned on a 32-bit data path.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] lo, input int data_w);
    logic mis;
    case (size)
      SZ_BYTE:   mis = 1'b0;
      SZ_HALF:   mis = lo[0];
      SZ_WORD:   mis = (lo[1:0] != 2'b00);
      SZ_DOUBLE: mis = (data_w < 64) || (lo != 3'b000);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory (slave).
interface mem_stage_lsu_if
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  localparam int BE_W = be_width(DATA_W);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, be, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack);
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Big-endian lane steering: store replication + byte enables, load extract + extend.
module mem_lane_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB    = be_width(DATA_W),
  localparam int OFF_W = $clog2(NB)
) (
  input  logic [1:0]        st_size_i,
  input  logic [OFF_W-1:0]  st_off_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [DATA_W-1:0] st_wdata_o,
  output logic [NB-1:0]     st_be_o,
  input  logic [1:0]        ld_size_i,
  input  logic [OFF_W-1:0]  ld_off_i,
  input  logic              ld_unsigned_i,
  input  logic [DATA_W-1:0] ld_rdata_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [OFF_W-1:0]  amask;
  logic [DATA_W-1:0] shifted;

  // Store path: replicate the datum across lanes; enable lanes whose offset matches under the size mask.
  always_comb begin
    st_wdata_o = st_data_i;
    amask      = '0;
    case (st_size_i)
      SZ_BYTE: begin
        st_wdata_o = {NB{st_data_i[7:0]}};
        amask      = '1;
      end
      SZ_HALF: begin
        st_wdata_o = {(NB/2){st_data_i[15:0]}};
        amask      = ~OFF_W'(1);
      end
      SZ_WORD: begin
        st_wdata_o = {(NB/4){st_data_i[31:0]}};
        amask      = ~OFF_W'(3);
      end
      default: begin
        st_wdata_o = st_data_i;
        amask      = '0;
      end
    endcase
    st_be_o = '0;
    for (int k = 0; k < NB; k++) begin
      st_be_o[NB-1-k] = ((OFF_W'(k) & amask) == (st_off_i & amask));
    end
  end

  // Load path: move the addressed lanes to the top, then extend from the top bit.
  always_comb begin
    shifted   = ld_rdata_i << {ld_off_i, 3'b000};
    ld_data_o = {DATA_W{~ld_unsigned_i & shifted[DATA_W-1]}};
    case (ld_size_i)
      SZ_BYTE: ld_data_o[7:0]  = shifted[DATA_W-1 -: 8];
      SZ_HALF: ld_data_o[15:0] = shifted[DATA_W-1 -: 16];
      SZ_WORD: ld_data_o[31:0] = shifted[DATA_W-1 -: 32];
      default: ld_data_o       = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage: multi-cycle req/ack data-memory access, stall generation and the M/W register.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_m,
  input  logic              mem_read_m,
  input  logic              mem_write_m,
  input  logic [1:0]        size_m,
  input  logic              unsigned_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [DATA_W-1:0] write_data_m,
  input  logic [DATA_W-1:0] result_w,
  input  logic              forward_mm,
  input  logic              reg_write_m,
  input  logic              mem_to_reg_m,
  input  logic [REG_W-1:0]  write_reg_m,
  mem_stage_lsu_if.master   mem,
  output logic              stall_m,
  output logic [DATA_W-1:0] alu_out_w,
  output logic [DATA_W-1:0] read_data_w,
  output logic              reg_write_w,
  output logic              mem_to_reg_w,
  output logic [REG_W-1:0]  write_reg_w,
  output logic              misalign_exc,
  output logic              timeout_exc
);

  localparam int         NB        = be_width(DATA_W);
  localparam int         OFF_W     = $clog2(NB);
  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic [OFF_W-1:0]  ld_off_q, ld_off_d;
  logic              ld_uns_q, ld_uns_d;
  logic [DATA_W-1:0] alu_q, alu_d, rd_q, rd_d;
  logic              rw_q, rw_d, mtr_q, mtr_d;
  logic [REG_W-1:0]  wreg_q, wreg_d;
  logic              mis_q, mis_d, tmo_q, tmo_d;

  logic              access, misaligned, stall;
  logic [DATA_W-1:0] st_wdata, ld_data;
  logic [NB-1:0]     st_be;

  assign access     = valid_m & (mem_read_m | mem_write_m);
  assign misaligned = is_misaligned(size_m, addr_m[2:0], DATA_W);

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .st_size_i     (size_m),
    .st_off_i      (addr_m[OFF_W-1:0]),
    .st_data_i     (forward_mm ? result_w : write_data_m),
    .st_wdata_o    (st_wdata),
    .st_be_o       (st_be),
    .ld_size_i     (ld_size_q),
    .ld_off_i      (ld_off_q),
    .ld_unsigned_i (ld_uns_q),
    .ld_rdata_i    (mem.rdata),
    .ld_data_o     (ld_data)
  );

  // Next-state: accept in IDLE, wait for ack or timeout in WAIT; W register holds while stalled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_uns_d  = ld_uns_q;
    alu_d     = alu_q;
    rd_d      = rd_q;
    rw_d      = rw_q;
    mtr_d     = mtr_q;
    wreg_d    = wreg_q;
    mis_d     = 1'b0;
    tmo_d     = 1'b0;
    stall     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          stall     = 1'b1;
          state_d   = ST_WAIT;
          cnt_d     = 8'd0;
          req_d     = 1'b1;
          we_d      = mem_write_m;
          addr_d    = {addr_m[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          wdata_d   = st_wdata;
          be_d      = st_be;
          ld_size_d = size_m;
          ld_off_d  = addr_m[OFF_W-1:0];
          ld_uns_d  = unsigned_m;
        end else begin
          alu_d  = addr_m;
          rd_d   = '0;
          rw_d   = reg_write_m & ~access;
          mtr_d  = mem_to_reg_m;
          wreg_d = write_reg_m;
          mis_d  = access;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.ack) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          alu_d   = addr_m;
          rd_d    = ld_data;
          rw_d    = reg_write_m;
          mtr_d   = mem_to_reg_m;
          wreg_d  = write_reg_m;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = ST_IDLE;
          cnt_d   = 8'd0;
          req_d   = 1'b0;
          we_d    = 1'b0;
          alu_d   = addr_m;
          rd_d    = '0;
          rw_d    = 1'b0;
          mtr_d   = mem_to_reg_m;
          wreg_d  = write_reg_m;
          tmo_d   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State, request and M/W registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      ld_size_q <= 2'b00;
      ld_off_q  <= '0;
      ld_uns_q  <= 1'b0;
      alu_q     <= '0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      mtr_q     <= 1'b0;
      wreg_q    <= '0;
      mis_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_uns_q  <= ld_uns_d;
      alu_q     <= alu_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      mtr_q     <= mtr_d;
      wreg_q    <= wreg_d;
      mis_q     <= mis_d;
      tmo_q     <= tmo_d;
    end
  end

  assign mem.req      = req_q;
  assign mem.we       = we_q;
  assign mem.addr     = addr_q;
  assign mem.wdata    = wdata_q;
  assign mem.be       = be_q;
  assign stall_m      = stall;
  assign alu_out_w    = alu_q;
  assign read_data_w  = rd_q;
  assign reg_write_w  = rw_q;
  assign mem_to_reg_w = mtr_q;
  assign write_reg_w  = wreg_q;
  assign misalign_exc = mis_q;
  assign timeout_exc  = tmo_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: driver queues expectations, monitors compare at negedge.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_m, mem_read_m, mem_write_m, unsigned_m, forward_mm;
  logic [1:0]  size_m;
  logic [31:0] addr_m, write_data_m, result_w;
  logic        reg_write_m, mem_to_reg_m;
  logic [4:0]  write_reg_m;
  logic        stall_m;
  logic [31:0] alu_out_w, read_data_w;
  logic        reg_write_w, mem_to_reg_w;
  logic [4:0]  write_reg_w;
  logic        misalign_exc, timeout_exc;

  typedef struct {
    logic [31:0] alu; logic [31:0] rd; logic rw; logic mtr; logic [4:0] wreg; logic mis; logic tmo;
  } wexp_t;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; int len;
  } rexp_t;

  wexp_t       wq[$];
  rexp_t       rq[$];
  int          checks = 0;
  int          errors = 0;
  logic        active = 1'b0;
  int          ack_delay = 0;
  logic [31:0] rdata_v = 32'h0;

  mem_stage_lsu_if #(.DATA_W(32), .ADDR_W(32)) mem_if ();
  assign mem_if.rdata = rdata_v;

  mem_stage_lsu #(.DATA_W(32), .ADDR_W(32), .REG_W(5), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .size_m(size_m), .unsigned_m(unsigned_m), .addr_m(addr_m), .write_data_m(write_data_m),
    .result_w(result_w), .forward_mm(forward_mm), .reg_write_m(reg_write_m), .mem_to_reg_m(mem_to_reg_m),
    .write_reg_m(write_reg_m), .mem(mem_if), .stall_m(stall_m), .alu_out_w(alu_out_w),
    .read_data_w(read_data_w), .reg_write_w(reg_write_w), .mem_to_reg_w(mem_to_reg_w),
    .write_reg_w(write_reg_w), .misalign_exc(misalign_exc), .timeout_exc(timeout_exc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic wexp_t mkw(input logic [31:0] alu, input logic [31:0] rd, input logic rw, input logic mtr,
                                input logic [4:0] wreg, input logic mis, input logic tmo);
    wexp_t e;
    e.alu = alu; e.rd = rd; e.rw = rw; e.mtr = mtr; e.wreg = wreg; e.mis = mis; e.tmo = tmo;
    return e;
  endfunction

  function automatic rexp_t mkr(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input int len);
    rexp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.len = len;
    return e;
  endfunction

  // Memory model: ack in WAIT cycle ack_delay (0 = never).
  initial begin : responder
    int wcnt;
    wcnt = 0;
    mem_if.ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_if.req === 1'b1) begin
        wcnt++;
        mem_if.ack = (wcnt == ack_delay);
      end else begin
        wcnt = 0;
        mem_if.ack = 1'b0;
      end
    end
  end

  // Request monitor: fields on every high cycle, length of the high run on the fall.
  initial begin : req_mon
    logic  prev;
    int    run;
    rexp_t cur;
    prev = 1'b0;
    run  = 0;
    cur  = mkr(1'b0, 32'h0, 32'h0, 4'h0, -1);
    forever begin
      @(negedge clk);
      if (mem_if.req === 1'b1) begin
        if (!prev) begin
          run = 0;
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req actual=addr 0x%0h required=no request", mem_if.addr);
            cur = mkr(1'b0, 32'h0, 32'h0, 4'h0, -1);
          end else begin
            cur = rq.pop_front();
          end
        end
        run++;
        if (cur.len >= 0) begin
          chk("req_we", {63'd0, mem_if.we}, {63'd0, cur.we});
          chk("req_addr", {32'd0, mem_if.addr}, {32'd0, cur.addr});
          chk("req_wdata", {32'd0, mem_if.wdata}, {32'd0, cur.wdata});
          chk("req_be", {60'd0, mem_if.be}, {60'd0, cur.be});
        end
      end else if (prev && cur.len >= 0) begin
        chk("req_len", 64'(run), 64'(cur.len));
      end
      prev = (mem_if.req === 1'b1);
    end
  end

  // W monitor: after a non-stalled cycle with a live instruction, W must show its expectation.
  initial begin : w_mon
    logic  armed;
    wexp_t e;
    armed = 1'b0;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL w_underflow actual=retire required=queued expectation");
        end else begin
          e = wq.pop_front();
          chk("alu_out_w", {32'd0, alu_out_w}, {32'd0, e.alu});
          chk("read_data_w", {32'd0, read_data_w}, {32'd0, e.rd});
          chk("reg_write_w", {63'd0, reg_write_w}, {63'd0, e.rw});
          chk("mem_to_reg_w", {63'd0, mem_to_reg_w}, {63'd0, e.mtr});
          chk("write_reg_w", {59'd0, write_reg_w}, {59'd0, e.wreg});
          chk("misalign_exc", {63'd0, misalign_exc}, {63'd0, e.mis});
          chk("timeout_exc", {63'd0, timeout_exc}, {63'd0, e.tmo});
        end
      end
      armed = active && (stall_m === 1'b0);
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_req"}, {63'd0, mem_if.req}, 64'd0);
    chk({tag, "_we"}, {63'd0, mem_if.we}, 64'd0);
    chk({tag, "_addr"}, {32'd0, mem_if.addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, mem_if.wdata}, 64'd0);
    chk({tag, "_be"}, {60'd0, mem_if.be}, 64'd0);
    chk({tag, "_alu"}, {32'd0, alu_out_w}, 64'd0);
    chk({tag, "_rd"}, {32'd0, read_data_w}, 64'd0);
    chk({tag, "_rw"}, {63'd0, reg_write_w}, 64'd0);
    chk({tag, "_mtr"}, {63'd0, mem_to_reg_w}, 64'd0);
    chk({tag, "_wreg"}, {59'd0, write_reg_w}, 64'd0);
    chk({tag, "_mis"}, {63'd0, misalign_exc}, 64'd0);
    chk({tag, "_tmo"}, {63'd0, timeout_exc}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall_m}, 64'd0);
  endtask

  task automatic issue(input string name, input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wd, input logic fwd,
                       input logic [31:0] resw, input logic rwm, input logic [4:0] wreg, input int dly,
                       input logic [31:0] rdat, input int exp_stalls, input wexp_t w);
    int stalls;
    stalls       = 0;
    ack_delay    = dly;
    rdata_v      = rdat;
    valid_m      = v;
    mem_read_m   = rd;
    mem_write_m  = wr;
    size_m       = sz;
    unsigned_m   = uns;
    addr_m       = addr;
    write_data_m = wd;
    forward_mm   = fwd;
    result_w     = resw;
    reg_write_m  = rwm;
    mem_to_reg_m = rd;
    write_reg_m  = wreg;
    active       = 1'b1;
    wq.push_back(w);
    forever begin
      @(negedge clk);
      if (stall_m === 1'b0) break;
      stalls++;
      if (stalls > 40) begin
        checks++; errors++;
        $display("FAIL %s_stall_bound actual=>40 cycles required=%0d", name, exp_stalls);
        break;
      end
      @(posedge clk); #1;
    end
    chk({name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin : driver
    reset = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0; size_m = 2'b00;
    unsigned_m = 1'b0; addr_m = 32'h0; write_data_m = 32'h0; result_w = 32'h0; forward_mm = 1'b0;
    reg_write_m = 1'b0; mem_to_reg_m = 1'b0; write_reg_m = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1;
    reset = 1'b0;

    issue("alu", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h55, 32'h0, 1'b0, 32'h0, 1'b1, 5'd3, 0, 32'h0, 0,
          mkw(32'h55, 32'h0, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0));
    rq.push_back(mkr(1'b1, 32'h100, 32'hDEADBEEF, 4'b1111, 1));
    issue("sw", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 5'd0, 1, 32'h0, 1,
          mkw(32'h100, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    rq.push_back(mkr(1'b0, 32'h100, 32'h0, 4'b0001, 2));
    issue("lb", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 2, 32'h000000F0, 2,
          mkw(32'h103, 32'hFFFFFFF0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0));
    rq.push_back(mkr(1'b0, 32'h100, 32'h0, 4'b0001, 1));
    issue("lbu", 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 1, 32'h000000F0, 1,
          mkw(32'h103, 32'h000000F0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0));
    rq.push_back(mkr(1'b1, 32'h100, 32'hABCDABCD, 4'b0011, 1));
    issue("sh_fwd", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h11111111, 1'b1, 32'h1234ABCD, 1'b0, 5'd0, 1,
          32'h0, 1, mkw(32'h102, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    rq.push_back(mkr(1'b0, 32'h200, 32'h0, 4'b0011, 3));
    issue("lh", 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b0, 32'h0, 1'b1, 5'd9, 3, 32'h12348765, 3,
          mkw(32'h202, 32'hFFFF8765, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0));
    rq.push_back(mkr(1'b0, 32'h100, 32'hC3C3C3C3, 4'b0100, 1));
    issue("lbu1", 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h101, 32'h000000C3, 1'b0, 32'h0, 1'b1, 5'd10, 1,
          32'hAABBCCDD, 1, mkw(32'h101, 32'h000000BB, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0));
    issue("lw_mis", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 1'b0, 32'h0, 1'b1, 5'd11, 1, 32'h0, 0,
          mkw(32'h101, 32'h0, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0));
    issue("alu2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h77, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 0, 32'h0, 0,
          mkw(32'h77, 32'h0, 1'b1, 1'b0, 5'd4, 1'b0, 1'b0));
    issue("ld_dbl", 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 32'h400, 32'h0, 1'b0, 32'h0, 1'b1, 5'd12, 1, 32'h0, 0,
          mkw(32'h400, 32'h0, 1'b0, 1'b1, 5'd12, 1'b1, 1'b0));
    rq.push_back(mkr(1'b0, 32'h300, 32'h0, 4'b1111, 4));
    issue("lw_tmo", 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0, 1'b1, 5'd13, 0, 32'h0, 4,
          mkw(32'h300, 32'h0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b1));
    issue("alu3", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h88, 32'h0, 1'b0, 32'h0, 1'b1, 5'd5, 0, 32'h0, 0,
          mkw(32'h88, 32'h0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0));

    // Abandon a load with reset in its second WAIT cycle.
    active = 1'b0;
    rq.push_back(mkr(1'b0, 32'h500, 32'h0, 4'b1111, 2));
    ack_delay = 0; valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; size_m = 2'b10;
    addr_m = 32'h500; write_data_m = 32'h0; forward_mm = 1'b0; reg_write_m = 1'b1; write_reg_m = 5'd14;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; valid_m = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset("rst_wait");
    @(posedge clk); #1;
    reset = 1'b0;

    rq.push_back(mkr(1'b1, 32'h104, 32'h0BADF00D, 4'b1111, 1));
    issue("sw2", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h104, 32'h0BADF00D, 1'b0, 32'h0, 1'b0, 5'd0, 1, 32'h0, 1,
          mkw(32'h104, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    issue("bubble", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h9, 32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 0, 32'h0, 0,
          mkw(32'h9, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0));
    active = 1'b0;
    repeat (2) @(negedge clk);
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("rq_empty", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
